door_lock_ctrl: RTL

//  Sequencing controller for the door-lock datapath. Collects keypad digits,

---
 rtl/door_lock_pkg.sv | 22 ++
 rtl/lock_timer.sv | 34 +++
 rtl/door_lock_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/door_lock_pkg.sv
// Shared types and constants for the door-lock sequencing controller.
package door_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCK,
        ST_ROTATE,
        ST_LOCKOUT
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by the entry-timeout, unlock-window and lockout phases.
module lock_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is the cycle the count sits at 1, so the owner leaves on the 1 -> 0 edge.
    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/door_lock_ctrl.sv
// Keypad code entry, password compare, unlock window, password refresh and lockout.
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int OPEN_CYCLES = 1000,
    parameter int ENTRY_TMO   = 5000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 20000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            digit_valid,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            clear,
    input  logic [DIGIT_W*DIGITS-1:0]       cur_pass,
    input  logic                            rotate_done,
    output logic                            unlock_door,
    output logic                            key_enable,
    output logic                            locked,
    output logic                            bad_digit,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

    localparam int PASS_W  = DIGIT_W * DIGITS;
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = max3(OPEN_CYCLES, ENTRY_TMO, LOCK_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t              state_q, state_d;
    logic [PASS_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    logic                unlock_q, key_en_q, locked_q, bad_q, bad_d;
    logic                tmr_load, tmr_expire;
    logic [TMR_W-1:0]    tmr_val;
    logic                digit_ok;

    assign digit_ok = digit_valid && (digit <= DIGIT_W'(BCD_MAX));
    assign fail_inc = fail_q + 1'b1;

    lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        bad_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                // Priority: clear, then digit, then idle timeout.
                if (clear) begin
                    state_d = ST_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (digit_valid && !digit_ok) begin
                    bad_d = 1'b1;
                end else if (digit_ok) begin
                    buf_d    = {buf_q[PASS_W-DIGIT_W-1:0], digit};
                    cnt_d    = cnt_q + 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ENTRY_TMO);
                    state_d  = (cnt_q == CNT_W'(DIGITS - 1)) ? ST_CHECK : ST_ENTRY;
                end else if ((state_q == ST_ENTRY) && tmr_expire) begin
                    state_d = ST_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (buf_q == cur_pass) begin
                    state_d  = ST_UNLOCK;
                    fail_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(OPEN_CYCLES);
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                        state_d  = ST_LOCKOUT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(LOCK_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNLOCK: begin
                if (tmr_expire) begin
                    state_d = ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                if (rotate_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            fail_q   <= '0;
            unlock_q <= 1'b0;
            key_en_q <= 1'b0;
            locked_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            unlock_q <= (state_d == ST_UNLOCK);
            key_en_q <= (state_d == ST_ROTATE);
            locked_q <= (state_d == ST_LOCKOUT);
            bad_q    <= bad_d;
        end
    end

    assign unlock_door = unlock_q;
    assign key_enable  = key_en_q;
    assign locked      = locked_q;
    assign bad_digit   = bad_q;
    assign fail_count  = fail_q;

endmodule
